// File: rtl/xbus_timer.sv
// xbus_timer: xbus slave s2 timer with prescaler, compare match, auto-reload and level interrupt.
// Reads are a combinational mux of register state; writes commit on the next rising edge.
module xbus_timer #(
    parameter int          PSC_W   = 16,
    parameter logic [31:0] CNT_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        we_i,
    output logic        int_o
);
    logic             r_en, r_int_en, r_pend, r_auto;
    logic [31:0]      r_count, r_cmp;
    logic [PSC_W-1:0] r_psc, r_psc_cnt;
    logic             w_sel, w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_psc;
    logic             w_tick, w_match, w_unused;

    assign w_unused   = ^{addr_i[31:28], addr_i[1:0]};
    assign w_sel      = addr_i[27:4] == 24'd0;
    assign w_wr_ctrl  = we_i & w_sel & (addr_i[3:2] == 2'd0);
    assign w_wr_count = we_i & w_sel & (addr_i[3:2] == 2'd1);
    assign w_wr_cmp   = we_i & w_sel & (addr_i[3:2] == 2'd2);
    assign w_wr_psc   = we_i & w_sel & (addr_i[3:2] == 2'd3);
    assign w_tick     = r_en & (r_psc_cnt == r_psc);
    // match is taken on the pre-write COUNT so a colliding software write cannot mask it
    assign w_match    = w_tick & (r_count == r_cmp);
    assign int_o      = r_pend & r_int_en;

    assign data_o = !w_sel                ? 32'd0 :
                    addr_i[3:2] == 2'd0   ? {28'd0, r_auto, r_pend, r_int_en, r_en} :
                    addr_i[3:2] == 2'd1   ? r_count :
                    addr_i[3:2] == 2'd2   ? r_cmp : 32'(r_psc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en      <= 1'b0;
            r_int_en  <= 1'b0;
            r_pend    <= 1'b0;
            r_auto    <= 1'b0;
            r_count   <= CNT_RST;
            r_cmp     <= 32'hFFFF_FFFF;
            r_psc     <= '0;
            r_psc_cnt <= '0;
        end else begin
            if (w_wr_ctrl) {r_auto, r_int_en, r_en} <= {data_i[3], data_i[1], data_i[0]};
            if (w_match) r_pend <= 1'b1;
            else if (w_wr_ctrl && data_i[2]) r_pend <= 1'b0;
            if (w_wr_count) r_count <= data_i;
            else if (w_tick) r_count <= (w_match && r_auto) ? 32'd0 : r_count + 32'd1;
            if (w_wr_cmp) r_cmp <= data_i;
            if (w_wr_psc) r_psc <= data_i[PSC_W-1:0];
            r_psc_cnt <= (w_wr_psc || !r_en || w_tick) ? '0 : r_psc_cnt + PSC_W'(1);
        end
    end
endmodule

// File: tb/tb_xbus_timer.sv
// tb_xbus_timer: directed register-level checks of xbus_timer with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
module tb_xbus_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        we_i = 1'b0;
    logic        int_o;
    int          n_chk = 0;
    int          n_fail = 0;

    xbus_timer dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o), .we_i(we_i), .int_o(int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we_i   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_i = a;
        #1;
        chk(tag, data_o, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        rst_n = 1'b1;
        rd("rst_ctrl", 32'h0, 32'h0);
        rd("rst_count", 32'h4, 32'h0);
        rd("rst_cmp", 32'h8, 32'hFFFF_FFFF);
        cyc(1);
        rd("rst_psc", 32'hC, 32'h0);
        chk("rst_int", {31'd0, int_o}, 32'h0);
        cyc(1);
        wr(32'h8, 32'hDEAD_BEEF);
        rd("cmp_rb", 32'h8, 32'hDEAD_BEEF);
        rd("oow_rd", 32'h10, 32'h0);
        cyc(1);
        wr(32'h10, 32'hFFFF_FFFF);
        rd("oow_ctrl", 32'h0, 32'h0);
        rd("oow_count", 32'h4, 32'h0);
        rd("oow_cmp", 32'h8, 32'hDEAD_BEEF);
        cyc(1);
        rd("oow_psc", 32'hC, 32'h0);
        cyc(1);

        // prescaler 3: one tick per 4 clocks
        wr(32'hC, 32'h3);
        wr(32'h4, 32'h0);
        wr(32'h0, 32'h1);
        rd("psc_readback", 32'hC, 32'h3);
        cyc(3);
        rd("psc_cnt_3clk", 32'h4, 32'h0);
        cyc(1);
        rd("psc_cnt_4clk", 32'h4, 32'h1);
        cyc(36);
        rd("psc_cnt_40clk", 32'h4, 32'd10);
        cyc(1);
        wr(32'h0, 32'h0);
        cyc(20);
        rd("psc_frozen", 32'h4, 32'd10);
        cyc(1);

        // compare match with interrupt
        wr(32'hC, 32'h0);
        wr(32'h8, 32'h5);
        wr(32'h4, 32'h0);
        wr(32'h0, 32'h3);
        cyc(5);
        rd("cmp_cnt5", 32'h4, 32'h5);
        rd("cmp_prematch_ctrl", 32'h0, 32'h3);
        chk("cmp_prematch_int", {31'd0, int_o}, 32'h0);
        cyc(1);
        rd("cmp_cnt6", 32'h4, 32'h6);
        rd("cmp_pend_ctrl", 32'h0, 32'h7);
        chk("cmp_int_set", {31'd0, int_o}, 32'h1);
        cyc(1);
        wr(32'h0, 32'h7);
        rd("w1c_ctrl", 32'h0, 32'h3);
        chk("w1c_int", {31'd0, int_o}, 32'h0);
        cyc(1);

        // auto-reload with interrupts masked
        wr(32'h0, 32'h0);
        wr(32'h8, 32'h2);
        wr(32'h4, 32'h0);
        wr(32'h0, 32'h9);
        rd("ar_c0", 32'h4, 32'h0);
        cyc(1);
        rd("ar_c1", 32'h4, 32'h1);
        cyc(1);
        rd("ar_c2", 32'h4, 32'h2);
        rd("ar_nopend", 32'h0, 32'h9);
        cyc(1);
        rd("ar_wrap0", 32'h4, 32'h0);
        rd("ar_pend", 32'h0, 32'hD);
        chk("ar_int_masked", {31'd0, int_o}, 32'h0);
        cyc(1);
        rd("ar_again1", 32'h4, 32'h1);
        cyc(1);
        wr(32'h0, 32'hB);
        rd("ar_unmask_ctrl", 32'h0, 32'hF);
        chk("ar_unmask_int", {31'd0, int_o}, 32'h1);
        cyc(1);

        // 32-bit wrap without match
        wr(32'h0, 32'h4);
        wr(32'h8, 32'h10);
        wr(32'h4, 32'hFFFF_FFFE);
        wr(32'h0, 32'h1);
        rd("wrap_fe", 32'h4, 32'hFFFF_FFFE);
        cyc(1);
        rd("wrap_ff", 32'h4, 32'hFFFF_FFFF);
        cyc(1);
        rd("wrap_00", 32'h4, 32'h0);
        cyc(1);
        rd("wrap_01", 32'h4, 32'h1);
        rd("wrap_nopend", 32'h0, 32'h1);
        cyc(1);

        // COUNT write in a matching tick cycle: write wins, match still seen
        wr(32'h0, 32'h0);
        wr(32'h4, 32'h7);
        wr(32'h8, 32'h7);
        wr(32'h0, 32'h1);
        wr(32'h4, 32'h100);
        rd("coll_cnt_write", 32'h4, 32'h100);
        rd("coll_pend_pre", 32'h0, 32'h5);
        wr(32'h8, 32'h101);
        rd("coll_cnt101", 32'h4, 32'h101);
        // PEND clear on the same edge as a new match
        wr(32'h0, 32'h5);
        rd("coll_set_wins", 32'h0, 32'h5);
        rd("coll_cnt102", 32'h4, 32'h102);
        cyc(1);
        wr(32'h0, 32'h3);
        chk("pre_rst_int", {31'd0, int_o}, 32'h1);
        addr_i = 32'h4;

        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", data_o, 32'h0);
        chk("arst_int", {31'd0, int_o}, 32'h0);
        addr_i = 32'h0;
        #1;
        chk("arst_ctrl", data_o, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        rd("post_rst_idle", 32'h4, 32'h0);
        rd("post_rst_cmp", 32'h8, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
